// File: rtl/condition_logic_vec_if.sv
// Bus bundle for condition_logic_vec: decoder-side requests in, gated controls out.
// The decoder/control side uses the master modport; the unit itself uses slave.
interface condition_logic_vec_if #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned STACK_DEPTH = 4
);
  localparam int unsigned CW = $clog2(STACK_DEPTH + 1);

  logic [2:0]         Opcode;
  logic [4*LANES-1:0] ALUFlags;
  logic [1:0]         FlagW;
  logic               PCS;
  logic               RegW;
  logic               MemW;
  logic [LANES-1:0]   lane_en;
  logic               stall;
  logic               flag_push;
  logic               flag_pop;

  logic [LANES-1:0]   cond_ex;
  logic               PCSrc;
  logic [LANES-1:0]   RegWrite;
  logic [LANES-1:0]   MemWrite;
  logic [4*LANES-1:0] flags_q;
  logic [CW-1:0]      stack_count;
  logic               stack_full;
  logic               stack_empty;
  logic               stack_err;

  modport master (
    output Opcode, ALUFlags, FlagW, PCS, RegW, MemW, lane_en, stall, flag_push, flag_pop,
    input  cond_ex, PCSrc, RegWrite, MemWrite, flags_q, stack_count,
           stack_full, stack_empty, stack_err
  );

  modport slave (
    input  Opcode, ALUFlags, FlagW, PCS, RegW, MemW, lane_en, stall, flag_push, flag_pop,
    output cond_ex, PCSrc, RegWrite, MemWrite, flags_q, stack_count,
           stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/condition_logic_vec.sv
// condition_logic_vec: per-lane NZCV flags, condition evaluation and gating of
// PCSrc / RegWrite / MemWrite, with an optional flag save/restore stack.
// Define CL_FLAG_STACK_EN to build the save/restore stack; without it the stack
// ports read as a permanently empty-and-full stack that never errors.
module condition_logic_vec #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned STACK_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  condition_logic_vec_if.slave bus
);
  localparam int unsigned CW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned FW = 4 * LANES;

  logic [FW-1:0]    r_flags;
  logic [FW-1:0]    w_flags_wr;
  logic [FW-1:0]    w_flags_d;
  logic [LANES-1:0] w_cond;
  logic [LANES-1:0] w_cond_ex;

  // Per-lane condition evaluation on the registered flags
  always_comb begin
    w_cond = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      unique case (bus.Opcode)
        3'b000:  w_cond[l] = 1'b1;
        3'b001:  w_cond[l] = r_flags[4*l+2];
        3'b010:  w_cond[l] = ~r_flags[4*l+2];
        3'b011:  w_cond[l] = r_flags[4*l+3] ^ r_flags[4*l];
        3'b100:  w_cond[l] = ~(r_flags[4*l+3] ^ r_flags[4*l]);
        3'b101:  w_cond[l] = r_flags[4*l+1];
        3'b110:  w_cond[l] = ~r_flags[4*l+1];
        default: w_cond[l] = 1'b0;
      endcase
    end
    w_cond_ex = bus.lane_en & w_cond;
  end

  assign bus.cond_ex  = w_cond_ex;
  assign bus.PCSrc    = bus.PCS & w_cond_ex[0];
  assign bus.RegWrite = {LANES{bus.RegW}} & w_cond_ex;
  assign bus.MemWrite = {LANES{bus.MemW}} & w_cond_ex;
  assign bus.flags_q  = r_flags;

  // Conditional NZ / CV field writes, only on lanes whose condition passed
  always_comb begin
    w_flags_wr = r_flags;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (bus.FlagW[1] && w_cond_ex[l])
        w_flags_wr[4*l+3 -: 2] = bus.ALUFlags[4*l+3 -: 2];
      if (bus.FlagW[0] && w_cond_ex[l])
        w_flags_wr[4*l+1 -: 2] = bus.ALUFlags[4*l+1 -: 2];
    end
  end

`ifdef CL_FLAG_STACK_EN
  localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [FW-1:0] r_stack [STACK_DEPTH];
  logic [CW-1:0] r_count;
  logic          r_err;
  logic          w_full;
  logic          w_empty;
  logic          w_push_req;
  logic          w_pop_req;
  logic          w_do_push;
  logic          w_do_pop;
  logic          w_err;
  logic [IW-1:0] w_wr_idx;
  logic [IW-1:0] w_rd_idx;

  assign w_full   = (r_count == CW'(STACK_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_wr_idx = IW'(r_count);
  assign w_rd_idx = IW'(r_count - CW'(1));

  // Stack request decode; simultaneous push+pop executes neither and flags an error
  always_comb begin
    w_push_req = bus.flag_push & ~bus.flag_pop;
    w_pop_req  = bus.flag_pop & ~bus.flag_push;
    w_do_push  = ~bus.stall & w_push_req & ~w_full;
    w_do_pop   = ~bus.stall & w_pop_req & ~w_empty;
    w_err      = ~bus.stall & ((bus.flag_push & bus.flag_pop) |
                               (w_push_req & w_full) | (w_pop_req & w_empty));
  end

  // A pop restore wins over any same-cycle flag write on every lane
  always_comb begin
    w_flags_d = w_flags_wr;
    if (w_do_pop)
      w_flags_d = r_stack[w_rd_idx];
  end

  // Snapshot storage: no reset, entries above count are never read
  always_ff @(posedge clk) begin
    if (!rst && w_do_push)
      r_stack[w_wr_idx] <= r_flags;
  end

  // Occupancy counter and registered error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_do_push)
        r_count <= r_count + CW'(1);
      else if (w_do_pop)
        r_count <= r_count - CW'(1);
    end
  end

  assign bus.stack_count = r_count;
  assign bus.stack_full  = w_full;
  assign bus.stack_empty = w_empty;
  assign bus.stack_err   = r_err;
`else
  logic w_unused_stack;

  assign w_unused_stack  = bus.flag_push ^ bus.flag_pop;
  assign w_flags_d       = w_flags_wr;
  assign bus.stack_count = '0;
  assign bus.stack_full  = 1'b1;
  assign bus.stack_empty = 1'b1;
  assign bus.stack_err   = 1'b0;
`endif

  // Flag register: reset clears, stall freezes
  always_ff @(posedge clk) begin
    if (rst)
      r_flags <= '0;
    else if (!bus.stall)
      r_flags <= w_flags_d;
  end
endmodule

// File: tb/tb_condition_logic_vec.sv
// Self-checking bench for condition_logic_vec (LANES=4, STACK_DEPTH=4).
module tb_condition_logic_vec;
  localparam int unsigned LANES = 4;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  condition_logic_vec_if #(.LANES(LANES), .STACK_DEPTH(DEPTH)) bus ();

  condition_logic_vec #(.LANES(LANES), .STACK_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [3:0]  m_fl [LANES];
  logic [15:0] m_stk [$];
  bit          m_err;

  function automatic bit cond_of(input logic [2:0] op, input logic [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (op)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n != v;
      3'd4: return n == v;
      3'd5: return c;
      3'd6: return !c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] m_ce();
    logic [3:0] r;
    for (int l = 0; l < LANES; l++)
      r[l] = bus.lane_en[l] && cond_of(bus.Opcode, m_fl[l]);
    return r;
  endfunction

  function automatic logic [15:0] m_flat();
    return {m_fl[3], m_fl[2], m_fl[1], m_fl[0]};
  endfunction

  task automatic m_load(input logic [15:0] v);
    for (int l = 0; l < LANES; l++) m_fl[l] = 4'((v >> (4 * l)) & 16'hF);
  endtask

  function automatic int m_count();
`ifdef CL_FLAG_STACK_EN
    return m_stk.size();
`else
    return 0;
`endif
  endfunction

  function automatic bit m_full();
`ifdef CL_FLAG_STACK_EN
    return m_stk.size() == DEPTH;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_edge();
    logic [3:0]  ce;
    logic [15:0] snap;
    logic [3:0]  nib;
    if (rst) begin
      for (int l = 0; l < LANES; l++) m_fl[l] = 4'h0;
      m_stk.delete();
      m_err = 0;
    end else if (bus.stall) begin
      m_err = 0;
    end else begin
      ce   = m_ce();
      snap = m_flat();
      for (int l = 0; l < LANES; l++) begin
        nib = 4'((bus.ALUFlags >> (4 * l)) & 16'hF);
        if (bus.FlagW[1] && ce[l]) m_fl[l][3:2] = nib[3:2];
        if (bus.FlagW[0] && ce[l]) m_fl[l][1:0] = nib[1:0];
      end
      m_err = 0;
`ifdef CL_FLAG_STACK_EN
      if (bus.flag_push && bus.flag_pop) m_err = 1;
      else if (bus.flag_push) begin
        if (m_stk.size() == DEPTH) m_err = 1;
        else m_stk.push_back(snap);
      end else if (bus.flag_pop) begin
        if (m_stk.size() == 0) m_err = 1;
        else m_load(m_stk.pop_back());
      end
`endif
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [3:0] ce;
    ce = m_ce();
    chk({tag, ".cond_ex"},  64'(bus.cond_ex),  64'(ce));
    chk({tag, ".PCSrc"},    64'(bus.PCSrc),    64'(bus.PCS & ce[0]));
    chk({tag, ".RegWrite"}, 64'(bus.RegWrite), 64'(bus.RegW ? ce : 4'h0));
    chk({tag, ".MemWrite"}, 64'(bus.MemWrite), 64'(bus.MemW ? ce : 4'h0));
    chk({tag, ".flags_q"},  64'(bus.flags_q),  64'(m_flat()));
    chk({tag, ".count"},    64'(bus.stack_count), 64'(m_count()));
    chk({tag, ".full"},     64'(bus.stack_full),  64'(m_full()));
    chk({tag, ".empty"},    64'(bus.stack_empty), 64'(m_count() == 0));
    chk({tag, ".err"},      64'(bus.stack_err),   64'(m_err));
  endtask

  task automatic idle();
    bus.Opcode = 3'd0; bus.ALUFlags = '0; bus.FlagW = 2'b00;
    bus.PCS = 0; bus.RegW = 0; bus.MemW = 0; bus.lane_en = 4'hF;
    bus.stall = 0; bus.flag_push = 0; bus.flag_pop = 0; rst = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit rst; bit stall; logic [2:0] op; logic [15:0] alu; logic [1:0] fw;
    logic [3:0] le; bit pcs; bit regw; bit memw;
    logic [3:0] e_ce; logic [15:0] e_fl; bit e_pc;
  } vec_t;

  vec_t tbl [13];

  initial begin
    idle();
    rst = 1;

    tbl[0]  = '{1, 0, 3'd0, 16'h0000, 2'b00, 4'hF, 0, 0, 0, 4'hF, 16'h0000, 0};
    tbl[1]  = '{0, 0, 3'd0, 16'h0404, 2'b10, 4'hF, 0, 1, 0, 4'hF, 16'h0404, 0};
    tbl[2]  = '{0, 0, 3'd1, 16'h0000, 2'b00, 4'hF, 0, 1, 1, 4'h5, 16'h0404, 0};
    tbl[3]  = '{0, 0, 3'd2, 16'h0000, 2'b00, 4'hF, 1, 0, 1, 4'hA, 16'h0404, 0};
    tbl[4]  = '{0, 0, 3'd0, 16'h0000, 2'b00, 4'hE, 1, 1, 0, 4'hE, 16'h0404, 0};
    tbl[5]  = '{0, 0, 3'd0, 16'h8129, 2'b11, 4'hF, 1, 0, 0, 4'hF, 16'h8129, 1};
    tbl[6]  = '{0, 0, 3'd3, 16'hFFFF, 2'b11, 4'hF, 1, 1, 1, 4'h0, 16'hFF29, 0};
    tbl[7]  = '{0, 0, 3'd4, 16'h0000, 2'b00, 4'hF, 0, 1, 0, 4'hF, 16'hFF29, 0};
    tbl[8]  = '{0, 0, 3'd5, 16'h0000, 2'b01, 4'hF, 0, 0, 1, 4'h0, 16'hCC09, 0};
    tbl[9]  = '{0, 0, 3'd6, 16'h0000, 2'b00, 4'hF, 1, 1, 1, 4'hF, 16'hCC09, 1};
    tbl[10] = '{0, 0, 3'd7, 16'hFFFF, 2'b11, 4'hF, 1, 1, 1, 4'h0, 16'hCC09, 0};
    tbl[11] = '{0, 1, 3'd0, 16'h0000, 2'b11, 4'hF, 0, 0, 0, 4'hF, 16'hCC09, 0};
    tbl[12] = '{1, 1, 3'd0, 16'h0000, 2'b00, 4'hF, 0, 0, 0, 4'hF, 16'h0000, 0};

    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; bus.stall = tbl[i].stall; bus.Opcode = tbl[i].op;
      bus.ALUFlags = tbl[i].alu; bus.FlagW = tbl[i].fw; bus.lane_en = tbl[i].le;
      bus.PCS = tbl[i].pcs; bus.RegW = tbl[i].regw; bus.MemW = tbl[i].memw;
      step();
      chk($sformatf("vec%0d.cond_ex", i),  64'(bus.cond_ex),  64'(tbl[i].e_ce));
      chk($sformatf("vec%0d.flags_q", i),  64'(bus.flags_q),  64'(tbl[i].e_fl));
      chk($sformatf("vec%0d.PCSrc", i),    64'(bus.PCSrc),    64'(tbl[i].e_pc));
      chk($sformatf("vec%0d.RegWrite", i), 64'(bus.RegWrite), 64'(tbl[i].regw ? tbl[i].e_ce : 4'h0));
      chk($sformatf("vec%0d.MemWrite", i), 64'(bus.MemWrite), 64'(tbl[i].memw ? tbl[i].e_ce : 4'h0));
    end
    check_model("after_table");

    // ---------------- stack corner sequences ----------------
    idle();
`ifdef CL_FLAG_STACK_EN
    chk("rst.empty", 64'(bus.stack_empty), 64'd1);
    chk("rst.full",  64'(bus.stack_full),  64'd0);
    bus.FlagW = 2'b11; bus.ALUFlags = 16'h1234; step();
    chk("loadA.flags", 64'(bus.flags_q), 64'h1234);
    bus.flag_push = 1; bus.ALUFlags = 16'h5678; step();
    chk("pushB.flags", 64'(bus.flags_q), 64'h5678);
    chk("pushB.count", 64'(bus.stack_count), 64'd1);
    bus.flag_push = 0; bus.flag_pop = 1; bus.ALUFlags = 16'h9999; step();
    chk("pop.flags", 64'(bus.flags_q), 64'h1234);
    chk("pop.count", 64'(bus.stack_count), 64'd0);
    chk("pop.err",   64'(bus.stack_err), 64'd0);
    bus.flag_pop = 0; bus.FlagW = 2'b00;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      bus.flag_push = 1; step();
      chk($sformatf("fill%0d.count", i), 64'(bus.stack_count), 64'(i > DEPTH ? DEPTH : i));
      chk($sformatf("fill%0d.err", i),   64'(bus.stack_err),   64'(i > DEPTH));
    end
    chk("fill.full", 64'(bus.stack_full), 64'd1);
    bus.flag_push = 0; step();
    chk("fill.err_clears", 64'(bus.stack_err), 64'd0);
    bus.flag_push = 1; bus.flag_pop = 1; bus.FlagW = 2'b11; bus.ALUFlags = 16'h0F0F; step();
    chk("pushpop.count", 64'(bus.stack_count), 64'(DEPTH));
    chk("pushpop.err",   64'(bus.stack_err),   64'd1);
    chk("pushpop.flags", 64'(bus.flags_q),     64'h0F0F);
    bus.flag_pop = 0; bus.stall = 1; bus.ALUFlags = 16'hAAAA; step();
    chk("stall.flags", 64'(bus.flags_q),     64'h0F0F);
    chk("stall.count", 64'(bus.stack_count), 64'(DEPTH));
    chk("stall.err",   64'(bus.stack_err),   64'd0);
    bus.stall = 0; bus.flag_push = 0; bus.FlagW = 2'b00; bus.flag_pop = 1;
    for (int i = 0; i < DEPTH; i++) step();
    chk("drain.flags", 64'(bus.flags_q), 64'h1234);
    chk("drain.empty", 64'(bus.stack_empty), 64'd1);
    step();
    chk("underflow.err",   64'(bus.stack_err), 64'd1);
    chk("underflow.flags", 64'(bus.flags_q),   64'h1234);
    bus.flag_pop = 0; bus.flag_push = 1; step();
    bus.flag_push = 0; bus.flag_pop = 1; rst = 1; step();
    chk("rstpop.flags", 64'(bus.flags_q),     64'h0);
    chk("rstpop.count", 64'(bus.stack_count), 64'd0);
    chk("rstpop.err",   64'(bus.stack_err),   64'd0);
`else
    bus.FlagW = 2'b11; bus.ALUFlags = 16'h1234; step();
    bus.FlagW = 2'b00; bus.flag_push = 1; step();
    chk("nostk.push.count", 64'(bus.stack_count), 64'd0);
    chk("nostk.push.err",   64'(bus.stack_err),   64'd0);
    chk("nostk.full",       64'(bus.stack_full),  64'd1);
    chk("nostk.empty",      64'(bus.stack_empty), 64'd1);
    bus.flag_push = 0; bus.flag_pop = 1; step();
    chk("nostk.pop.flags", 64'(bus.flags_q),     64'h1234);
    chk("nostk.pop.count", 64'(bus.stack_count), 64'd0);
    chk("nostk.pop.err",   64'(bus.stack_err),   64'd0);
`endif
    check_model("after_seq");

    // ---------------- randomized vs model ----------------
    idle();
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 39) == 0);
      bus.stall     = ($urandom_range(0, 7) == 0);
      bus.Opcode    = 3'($urandom);
      bus.ALUFlags  = 16'($urandom);
      bus.FlagW     = 2'($urandom);
      bus.lane_en   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      bus.PCS       = 1'($urandom);
      bus.RegW      = 1'($urandom);
      bus.MemW      = 1'($urandom);
      bus.flag_push = ($urandom_range(0, 3) == 0);
      bus.flag_pop  = ($urandom_range(0, 3) == 0);
      step();
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
